hdr_merge_accum: RTL and testbench
==================================

# hdr_merge_accum

Upstream feeder for the 36-bit pipelined divider in the HDR merge path. Takes the N_EXP bracketed exposure samples of one pixel as a serial stream, applies the hat weighting function and per-exposure gain, and accumulates the weighted-radiance numerator and weight-sum denominator. Once per pixel it emits a single-cycle `div_valid` pulse with `div_num`/`div_den` to the divider. The divider has no backpressure, so this block never stalls. It also guarantees a non-zero denominator, including for fully saturated pixels.

## Interface
- `PIX_W`, default 8: pixel sample width.
- `GAIN_W`, default 16: per-exposure gain width (unsigned integer).
- `N_EXP`, default 3: exposures per pixel. Index 0 is the longest exposure; index N_EXP-1 is the shortest.
- `OUT_W`, default 36: divider operand width.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `pix_valid`  in  1: sample present this cycle. No ready; every valid sample is consumed.
- `pix_first`  in  1: qualifies `pix_valid`; marks exposure 0 of a pixel tuple.
- `pix_data`  in  PIX_W: sample value z.
- `gain`  in  N_EXP*GAIN_W: gain of exposure i at `[i*GAIN_W +: GAIN_W]`; quasi-static.
- `div_valid`  out  1: one-cycle strobe; operands valid.
- `div_num`  out  OUT_W: numerator.
- `div_den`  out  OUT_W: denominator, never 0.
- `tuple_err`  out  1: one-cycle strobe on a framing violation.

## Operation
- Exposure counter `idx` runs 0..N_EXP-1. States: IDLE (`idx`=0, no tuple open) and ACCUM.
- Weight: w = z when z <= 2^(PIX_W-1)-1; otherwise w = (2^PIX_W-1) - z. For 8-bit pixels this gives 0 for z=0 and z=255, and a peak of 127.
- Product: p = w * z * gain[idx], 2*PIX_W+GAIN_W bits.
- Accumulation: num = sum of p; den = sum of w. Both are zero-extended to OUT_W, with no overflow at the default widths (34 bits maximum).
- `sat_hi` is set if any sample in the tuple equals 2^PIX_W-1.
- Zero-weight fallback, applied when den==0 at tuple end:
  - If `sat_hi`: num = (2^PIX_W-1) * gain[N_EXP-1], den = 1.
  - Otherwise: num = 0, den = 1.
- Framing rules:
  - `pix_valid & pix_first` while ACCUM: pulse `tuple_err`, discard the partial sums, and start a new tuple with this sample as exposure 0.
  - `pix_valid & ~pix_first` while IDLE: pulse `tuple_err` and drop the sample.
  - Sample N_EXP-1 closes the tuple: return to IDLE and issue the output.
- `pix_valid` low simply holds state; gaps inside a tuple are legal.
- Reset values: `div_valid`=0, `div_num`=0, `div_den`=0, `tuple_err`=0, state IDLE, accumulators 0, pipeline valids 0. Reset mid-tuple discards the tuple and emits no output.

## Timing
- Stage S1 (registered): w, p, idx, last flag, sample-valid, saturation bit.
- Stage S2 (registered): accumulators, fallback, output registers.
- Latency: last sample accepted at cycle t produces `div_valid` at t+2.
- Divider result therefore appears at t+5, since the divider's valid-to-ready latency is 3.
- Throughput: one sample per cycle. Back-to-back tuples give `div_valid` every N_EXP cycles.
- Accumulators clear in the same cycle that the closing sample's S2 update is written, so the next tuple's exposure 0 in S2 starts from zero with no bubble.
- `tuple_err` asserts 1 cycle after the offending sample is presented.
- `div_num`/`div_den` hold their values between strobes.

## Structure
- Shared package `hdr_pkg`:
  - Constants `PIX_W`, `GAIN_W`, `N_EXP`, `OUT_W`, `PIX_MAX`, `PIX_MID`.
  - Hat-weight function.
  - Divider operand typedef, shared with `div_36bit` consumers.
- One sub-module, `hdr_weight_mult`: combinational weight plus w*z*gain product, feeding the S1 registers. Isolates the multiplier for DSP inference.

## Test plan
- Tuple (100,50,20) with gains (1,4,16) → one strobe 2 cycles after the last sample: num=26400, den=170, `tuple_err`=0.
- Tuple (255,200,60) with the same gains → num=101600, den=115.
- Tuple (255,255,255) → num=4080, den=1. Tuple (0,0,0) → num=0, den=1.
- 4 back-to-back tuples with `pix_valid` held high → `div_valid` strobes spaced exactly 3 cycles apart. Randomised gaps inside tuples → sums unchanged.
- Framing errors:
  - `pix_first` at idx 1 → `tuple_err` pulse; the new tuple (10,10,10) gives num=2100, den=30.
  - Non-first sample in IDLE → `tuple_err` pulse, no output.
- `rst_n` low for 1 cycle after 2 samples → all outputs 0, no strobe; the next full tuple is correct.

Source files
------------

// File: rtl/hdr_merge_accum_pkg.sv
// Shared HDR merge definitions: widths, weight constants, hat weight,
// FSM state type and the divider operand bundle.
package hdr_pkg;

  localparam int PIX_W  = 8;
  localparam int GAIN_W = 16;
  localparam int N_EXP  = 3;
  localparam int OUT_W  = 36;
  localparam int PROD_W = 2 * PIX_W + GAIN_W;

  localparam logic [PIX_W-1:0] PIX_MAX = '1;
  localparam logic [PIX_W-1:0] PIX_MID = PIX_MAX >> 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Operand pair handed to div_36bit consumers.
  typedef struct packed {
    logic [OUT_W-1:0] num;
    logic [OUT_W-1:0] den;
  } div_operand_t;

  // Hat weight: rises with z up to the mid code, then falls to 0 at full scale.
  function automatic logic [PIX_W-1:0] hat_weight(input logic [PIX_W-1:0] z);
    return (z <= PIX_MID) ? z : (PIX_MAX - z);
  endfunction

endpackage

// File: rtl/hdr_merge_accum_if.sv
// Pixel-in / divider-out bundle for hdr_merge_accum.
// Handshake: pix_valid has no ready, every valid sample is consumed on the
// clock edge; div_valid and tuple_err are single-cycle strobes with no
// backpressure, div_num/div_den are meaningful while div_valid is high and
// hold their last values otherwise.
interface hdr_merge_accum_if #(
  parameter int PIX_W  = hdr_pkg::PIX_W,
  parameter int GAIN_W = hdr_pkg::GAIN_W,
  parameter int N_EXP  = hdr_pkg::N_EXP,
  parameter int OUT_W  = hdr_pkg::OUT_W
);
  import hdr_pkg::*;

  logic                    pix_valid;
  logic                    pix_first;
  logic [PIX_W-1:0]        pix_data;
  logic [N_EXP*GAIN_W-1:0] gain;
  logic                    div_valid;
  logic [OUT_W-1:0]        div_num;
  logic [OUT_W-1:0]        div_den;
  logic                    tuple_err;
  state_t                  dbg_state;

  modport master (
    output pix_valid, pix_first, pix_data, gain,
    input  div_valid, div_num, div_den, tuple_err, dbg_state
  );

  modport slave (
    input  pix_valid, pix_first, pix_data, gain,
    output div_valid, div_num, div_den, tuple_err, dbg_state
  );

endinterface

// File: rtl/hdr_merge_accum_weight_mult.sv
// Combinational hat weight and w*z*gain product, kept on its own so the
// multiplier maps cleanly onto DSP blocks ahead of the S1 registers.
module hdr_weight_mult #(
  parameter int PIX_W  = hdr_pkg::PIX_W,
  parameter int GAIN_W = hdr_pkg::GAIN_W,
  parameter int PROD_W = 2 * PIX_W + GAIN_W
) (
  input  logic [PIX_W-1:0]  z,
  input  logic [GAIN_W-1:0] gain_sel,
  output logic [PIX_W-1:0]  w,
  output logic [PROD_W-1:0] p
);
  localparam logic [PIX_W-1:0] Z_MAX = '1;
  localparam logic [PIX_W-1:0] Z_MID = Z_MAX >> 1;

  // Weight the sample, then scale by its value and the exposure gain.
  always_comb begin
    w = (z <= Z_MID) ? z : (Z_MAX - z);
    p = PROD_W'(w) * PROD_W'(z) * PROD_W'(gain_sel);
  end

endmodule

// File: rtl/hdr_merge_accum.sv
// HDR merge accumulator: frames N_EXP serial exposures per pixel, weights
// and gains each sample (S1), accumulates numerator/denominator (S2) and
// strobes one divider operand pair per pixel. Never stalls.
module hdr_merge_accum #(
  parameter int PIX_W  = hdr_pkg::PIX_W,
  parameter int GAIN_W = hdr_pkg::GAIN_W,
  parameter int N_EXP  = hdr_pkg::N_EXP,
  parameter int OUT_W  = hdr_pkg::OUT_W
) (
  input logic              clk,
  input logic              rst_n,
  hdr_merge_accum_if.slave bus
);
  import hdr_pkg::*;

  localparam int IDX_W = (N_EXP > 1) ? $clog2(N_EXP) : 1;
  localparam int P_W   = 2 * PIX_W + GAIN_W;
  localparam logic [PIX_W-1:0] Z_MAX = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_EXP - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_use;
  logic             accept, last, err;

  logic [GAIN_W-1:0] gain_sel;
  logic [PIX_W-1:0]  w_c;
  logic [P_W-1:0]    p_c;

  logic             s1_valid, s1_first, s1_last, s1_sat;
  logic [PIX_W-1:0] s1_w;
  logic [P_W-1:0]   s1_p;
  logic [IDX_W-1:0] s1_idx;

  logic [OUT_W-1:0] acc_num, acc_den, num_sum, den_sum, fb_num;
  logic             acc_sat, sat_sum;

  logic             div_valid_q, tuple_err_q;
  logic [OUT_W-1:0] div_num_q, div_den_q;

  // Framing state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Framing decode: a first sample always (re)starts at exposure 0, a
  // non-first sample is only taken inside an open tuple.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    idx_use = idx_q;
    accept  = 1'b0;
    err     = 1'b0;
    if (bus.pix_valid) begin
      if (bus.pix_first) begin
        accept  = 1'b1;
        idx_use = '0;
        err     = (state_q == ST_ACCUM);
      end else if (state_q == ST_ACCUM) begin
        accept = 1'b1;
      end else begin
        err = 1'b1;
      end
    end
    last = accept && (idx_use == IDX_LAST);
    if (accept) begin
      if (last) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        state_d = ST_ACCUM;
        idx_d   = idx_use + 1'b1;
      end
    end
  end

  assign gain_sel = bus.gain[int'(idx_use)*GAIN_W +: GAIN_W];

  hdr_weight_mult #(
    .PIX_W  (PIX_W),
    .GAIN_W (GAIN_W),
    .PROD_W (P_W)
  ) u_weight_mult (
    .z        (bus.pix_data),
    .gain_sel (gain_sel),
    .w        (w_c),
    .p        (p_c)
  );

  // S1: register weight, product and per-sample tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_sat      <= 1'b0;
      s1_w        <= '0;
      s1_p        <= '0;
      s1_idx      <= '0;
      tuple_err_q <= 1'b0;
    end else begin
      s1_valid    <= accept;
      s1_first    <= accept && (idx_use == '0);
      s1_last     <= last;
      s1_sat      <= (bus.pix_data == Z_MAX);
      s1_w        <= w_c;
      s1_p        <= p_c;
      s1_idx      <= idx_use;
      tuple_err_q <= err;
    end
  end

  // Exposure 0 ignores whatever partial sums are left, which is how an
  // aborted tuple is discarded without an extra clear cycle.
  always_comb begin
    num_sum = (s1_first ? '0 : acc_num) + OUT_W'(s1_p);
    den_sum = (s1_first ? '0 : acc_den) + OUT_W'(s1_w);
    sat_sum = s1_sat | (~s1_first & acc_sat);
    fb_num  = OUT_W'(Z_MAX) * OUT_W'(bus.gain[(N_EXP-1)*GAIN_W +: GAIN_W]);
  end

  // S2: accumulate, apply zero-weight fallback and register the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_num     <= '0;
      acc_den     <= '0;
      acc_sat     <= 1'b0;
      div_valid_q <= 1'b0;
      div_num_q   <= '0;
      div_den_q   <= '0;
    end else begin
      div_valid_q <= 1'b0;
      if (s1_valid) begin
        if (s1_last) begin
          acc_num     <= '0;
          acc_den     <= '0;
          acc_sat     <= 1'b0;
          div_valid_q <= 1'b1;
          if (den_sum == '0) begin
            div_num_q <= sat_sum ? fb_num : '0;
            div_den_q <= OUT_W'(1);
          end else begin
            div_num_q <= num_sum;
            div_den_q <= den_sum;
          end
        end else begin
          acc_num <= num_sum;
          acc_den <= den_sum;
          acc_sat <= sat_sum;
        end
      end
    end
  end

  assign bus.div_valid = div_valid_q;
  assign bus.div_num   = div_num_q;
  assign bus.div_den   = div_den_q;
  assign bus.tuple_err = tuple_err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_hdr_merge_accum.sv
// Bench for hdr_merge_accum: directed pixel tuples with hand-computed
// divider operands, expected strobes queued with their due cycle and
// checked by an independent monitor.
module tb_hdr_merge_accum;
  import hdr_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  logic [35:0] exp_num_q[$];
  logic [35:0] exp_den_q[$];
  int          exp_cyc_q[$];
  int          err_cyc_q[$];

  hdr_merge_accum_if bus ();

  hdr_merge_accum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic drive(input logic first, input logic [7:0] z);
    @(posedge clk); #1;
    bus.pix_valid = 1'b1;
    bus.pix_first = first;
    bus.pix_data  = z;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.pix_valid = 1'b0;
      bus.pix_first = 1'b0;
    end
  endtask

  task automatic expect_out(input logic [35:0] num, input logic [35:0] den);
    exp_num_q.push_back(num);
    exp_den_q.push_back(den);
    exp_cyc_q.push_back(cyc + 2);
  endtask

  task automatic send_tuple(input logic [7:0] z0, input logic [7:0] z1, input logic [7:0] z2,
                            input logic [35:0] num, input logic [35:0] den, input int max_gap);
    drive(1'b1, z0);
    if (max_gap > 0) idle($urandom_range(0, max_gap));
    drive(1'b0, z1);
    if (max_gap > 0) idle($urandom_range(0, max_gap));
    drive(1'b0, z2);
    expect_out(num, den);
  endtask

  // Monitor: compare every strobe against the scoreboard heads.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.div_valid) begin
        if (exp_cyc_q.size() == 0) begin
          chk("unexpected_div_valid", 64'd1, 64'd0);
        end else begin
          chk("div_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
          chk("div_num", 64'(bus.div_num), 64'(exp_num_q.pop_front()));
          chk("div_den", 64'(bus.div_den), 64'(exp_den_q.pop_front()));
        end
      end
      if (bus.tuple_err) begin
        if (err_cyc_q.size() == 0) chk("unexpected_tuple_err", 64'd1, 64'd0);
        else chk("tuple_err_cycle", 64'(cyc), 64'(err_cyc_q.pop_front()));
      end
    end
  end

  task automatic check_quiet_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_div_valid"}, 64'(bus.div_valid), 64'd0);
    chk({tag, "_div_num"},   64'(bus.div_num),   64'd0);
    chk({tag, "_div_den"},   64'(bus.div_den),   64'd0);
    chk({tag, "_tuple_err"}, 64'(bus.tuple_err), 64'd0);
    chk({tag, "_state"},     64'(bus.dbg_state), 64'(ST_IDLE));
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 50;
    while ((exp_cyc_q.size() != 0 || err_cyc_q.size() != 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    idle(4);
    chk({tag, "_pending_outputs"}, 64'(exp_cyc_q.size()), 64'd0);
    chk({tag, "_pending_errors"},  64'(err_cyc_q.size()),  64'd0);
  endtask

  initial begin
    cyc           = 0;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_first = 1'b0;
    bus.pix_data  = '0;
    bus.gain      = {16'd16, 16'd4, 16'd1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_quiet_outputs("reset");

    // Nominal, saturated-long and fallback tuples.
    idle(2);
    send_tuple(8'd100, 8'd50,  8'd20,  36'd26400,  36'd170, 0);
    idle(4);
    send_tuple(8'd255, 8'd200, 8'd60,  36'd101600, 36'd115, 0);
    idle(4);
    send_tuple(8'd255, 8'd255, 8'd255, 36'd4080,   36'd1,   0);
    idle(4);
    send_tuple(8'd0,   8'd0,   8'd0,   36'd0,      36'd1,   0);
    idle(4);
    drain("directed");

    // Four back-to-back tuples: strobes due every 3 cycles.
    send_tuple(8'd100, 8'd50,  8'd20,  36'd26400,  36'd170, 0);
    send_tuple(8'd255, 8'd200, 8'd60,  36'd101600, 36'd115, 0);
    send_tuple(8'd10,  8'd10,  8'd10,  36'd2100,   36'd30,  0);
    send_tuple(8'd255, 8'd255, 8'd255, 36'd4080,   36'd1,   0);
    idle(1);
    drain("back_to_back");

    // Gaps inside tuples leave the sums unchanged.
    for (int i = 0; i < 3; i++) begin
      send_tuple(8'd100, 8'd50, 8'd20, 36'd26400, 36'd170, 3);
      idle($urandom_range(0, 3));
      send_tuple(8'd255, 8'd200, 8'd60, 36'd101600, 36'd115, 3);
      idle(1);
    end
    drain("gaps");

    // First flag at exposure 1 aborts the open tuple and restarts.
    drive(1'b1, 8'd100);
    drive(1'b1, 8'd10);
    err_cyc_q.push_back(cyc + 1);
    drive(1'b0, 8'd10);
    drive(1'b0, 8'd10);
    expect_out(36'd2100, 36'd30);
    idle(1);
    drain("restart");

    // Non-first sample while idle is dropped with an error strobe.
    drive(1'b0, 8'd77);
    err_cyc_q.push_back(cyc + 1);
    idle(1);
    drain("orphan");
    chk("orphan_state", 64'(bus.dbg_state), 64'(ST_IDLE));

    // Reset after two samples: no strobe, outputs cleared, then recovery.
    drive(1'b1, 8'd100);
    drive(1'b0, 8'd50);
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_quiet_outputs("mid_reset");
    send_tuple(8'd100, 8'd50, 8'd20, 36'd26400, 36'd170, 0);
    idle(1);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends with a summary.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
